// File: rtl/rtc_disp_pkg.sv
// Shared display constants for the RTC seven-segment path.
// Segment vectors are {a,b,c,d,e,f,g}: bit6 = a down to bit0 = g, active-high.
package rtc_disp_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'b1111110;
  localparam seg_t SEG_1     = 7'b0110000;
  localparam seg_t SEG_2     = 7'b1101101;
  localparam seg_t SEG_3     = 7'b1111001;
  localparam seg_t SEG_4     = 7'b0110011;
  localparam seg_t SEG_5     = 7'b1011011;
  localparam seg_t SEG_6     = 7'b1011111;
  localparam seg_t SEG_7     = 7'b1110000;
  localparam seg_t SEG_8     = 7'b1111111;
  localparam seg_t SEG_9     = 7'b1111011;
  localparam seg_t SEG_A     = 7'b1110111;
  localparam seg_t SEG_B     = 7'b0011111;
  localparam seg_t SEG_C     = 7'b1001110;
  localparam seg_t SEG_D     = 7'b0111101;
  localparam seg_t SEG_E     = 7'b1001111;
  localparam seg_t SEG_F     = 7'b1000111;
  localparam seg_t SEG_BLANK = 7'b0000000;

  // $clog2 that never yields a zero-width vector.
  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rtc_7seg_dec.sv
// Combinational 4-bit code to active-high seven-segment pattern.
// Codes 10-15 decode to hex letters only when hex_en is set, otherwise blank.
module rtc_7seg_dec
  import rtc_disp_pkg::*;
(
  input  logic [3:0] code,
  input  logic       hex_en,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      4'd0:  seg = SEG_0;
      4'd1:  seg = SEG_1;
      4'd2:  seg = SEG_2;
      4'd3:  seg = SEG_3;
      4'd4:  seg = SEG_4;
      4'd5:  seg = SEG_5;
      4'd6:  seg = SEG_6;
      4'd7:  seg = SEG_7;
      4'd8:  seg = SEG_8;
      4'd9:  seg = SEG_9;
      4'd10: seg = hex_en ? SEG_A : SEG_BLANK;
      4'd11: seg = hex_en ? SEG_B : SEG_BLANK;
      4'd12: seg = hex_en ? SEG_C : SEG_BLANK;
      4'd13: seg = hex_en ? SEG_D : SEG_BLANK;
      4'd14: seg = hex_en ? SEG_E : SEG_BLANK;
      4'd15: seg = hex_en ? SEG_F : SEG_BLANK;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/rtc_7seg_scan_mux.sv
// Time-multiplexed N-digit seven-segment driver with tear-free frame buffering,
// leading-zero blanking and per-slot brightness PWM. All pin outputs are registered.
module rtc_7seg_scan_mux
  import rtc_disp_pkg::*;
#(
  parameter int NUM_DIGITS     = 6,
  parameter int SCAN_DIV       = 1000,
  parameter int HEX_EN         = 0,
  parameter int BLANK_LZ       = 1,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [3:0]              brightness,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_done
);

  localparam int SW = width_of(SCAN_DIV);
  localparam int IW = width_of(NUM_DIGITS);
  localparam int PW = SW + 5;
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  logic [SW-1:0]             slot_cnt;
  logic [IW-1:0]             idx;
  logic [4*NUM_DIGITS-1:0]   pend_dig, act_dig;
  logic [NUM_DIGITS-1:0]     pend_dp, act_dp;
  logic [NUM_DIGITS-1:0]     blank_mask;
  logic                      zero_run;
  logic [3:0]                cur_nib;
  logic                      cur_dp, cur_blank;
  logic [6:0]                dec_seg;
  logic [PW-1:0]             bright_p1, on_len;
  logic                      pwm_on, frame_start;
  logic [6:0]                seg_q;
  logic                      dp_q;
  logic [NUM_DIGITS-1:0]     dig_q;

  assign frame_start = en && (slot_cnt == '0) && (idx == '0);
  assign frame_done  = en && (slot_cnt == SLOT_LAST) && (idx == IDX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      idx      <= '0;
    end else if (!en) begin
      slot_cnt <= '0;
      idx      <= '0;
    end else if (slot_cnt == SLOT_LAST) begin
      slot_cnt <= '0;
      idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  // Active copy only at frame start, so a mid-frame load never tears the display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_dig <= '0;
      pend_dp  <= '0;
      act_dig  <= '0;
      act_dp   <= '0;
    end else begin
      if (load) begin
        pend_dig <= digits_in;
        pend_dp  <= dp_in;
      end
      if (frame_start) begin
        act_dig <= pend_dig;
        act_dp  <= pend_dp;
      end
    end
  end

  always_comb begin
    blank_mask = '0;
    zero_run   = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_run      = zero_run && (act_dig[4*k +: 4] == 4'd0);
      blank_mask[k] = (BLANK_LZ != 0) && zero_run;
    end
  end

  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IW'(k)) begin
        cur_nib   = act_dig[4*k +: 4];
        cur_dp    = act_dp[k];
        cur_blank = blank_mask[k];
      end
    end
  end

  rtc_7seg_dec u_dec (
    .code   (cur_nib),
    .hex_en (HEX_EN != 0),
    .seg    (dec_seg)
  );

  // Slot cycle 0 stays dark so the previous digit's segments never ghost onto the next select.
  assign bright_p1 = {{(PW-4){1'b0}}, brightness} + PW'(1);
  assign on_len    = (bright_p1 * PW'(SCAN_DIV)) >> 4;
  assign pwm_on    = en && (slot_cnt != '0) && ({5'b0, slot_cnt} <= on_len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= '0;
      dp_q  <= 1'b0;
      dig_q <= '0;
    end else begin
      seg_q <= (pwm_on && !cur_blank) ? dec_seg : '0;
      dp_q  <= pwm_on && cur_dp;
      dig_q <= pwm_on ? (NUM_DIGITS'(1) << idx) : '0;
    end
  end

  assign seg_out = (SEG_ACTIVE_LOW != 0) ? ~seg_q : seg_q;
  assign dp_out  = (SEG_ACTIVE_LOW != 0) ? ~dp_q  : dp_q;
  assign dig_sel = (DIG_ACTIVE_LOW != 0) ? ~dig_q : dig_q;

endmodule

// File: tb/tb_rtc_7seg_scan_mux.sv
// Scoreboard bench: a cycle-time model of the scanned display queues expected pin
// values per clock; a monitor pops and compares them against two DUTs (HEX_EN 0 and 1).
module tb_rtc_7seg_scan_mux;

  localparam int ND = 4;
  localparam int SD = 16;
  localparam int FRAME = ND * SD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic load = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0] dp_in = '0;
  logic [3:0] brightness = '0;

  logic [6:0] seg0, seg1;
  logic dp0, dp1, fd0, fd1;
  logic [3:0] dig0, dig1;

  always #5 clk = ~clk;

  rtc_7seg_scan_mux #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .HEX_EN(0), .BLANK_LZ(1),
                      .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .digits_in(digits_in),
    .dp_in(dp_in), .brightness(brightness), .seg_out(seg0), .dp_out(dp0),
    .dig_sel(dig0), .frame_done(fd0));

  rtc_7seg_scan_mux #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .HEX_EN(1), .BLANK_LZ(1),
                      .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(1)) dut_hex (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .digits_in(digits_in),
    .dp_in(dp_in), .brightness(brightness), .seg_out(seg1), .dp_out(dp1),
    .dig_sel(dig1), .frame_done(fd1));

  typedef struct {
    logic [6:0] seg_dec;
    logic [6:0] seg_hex;
    logic       dp;
    logic [3:0] dig;
    logic       fd;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  // Reference model state: cycles elapsed since scanning (re)started.
  int t = 0;
  logic [15:0] m_pend = '0, m_act = '0;
  logic [3:0]  m_pend_dp = '0, m_act_dp = '0;
  logic [6:0]  pat [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] decode(input logic [3:0] c, input bit hex);
    if (c >= 4'd10 && !hex) return 7'b0000000;
    return pat[c];
  endfunction

  task automatic step(input bit e, input bit ld, input logic [15:0] d,
                      input logic [3:0] p, input logic [3:0] b);
    exp_t x;
    int slot, di;
    bit on, blank;
    logic [3:0] nib;
    @(negedge clk);
    en = e; load = ld; digits_in = d; dp_in = p; brightness = b;
    x.seg_dec = '0; x.seg_hex = '0; x.dp = 1'b0; x.dig = 4'hF; x.fd = 1'b0;
    if (e) begin
      if (t % FRAME == 0) begin
        m_act = m_pend;
        m_act_dp = m_pend_dp;
      end
      slot = t % SD;
      di = (t / SD) % ND;
      on = (slot >= 1) && (slot <= ((int'(b) + 1) * SD) / 16);
      if (on) begin
        nib = m_act[di*4 +: 4];
        blank = 1'b0;
        if (di > 0) begin
          blank = 1'b1;
          for (int j = di; j < ND; j++) if (m_act[j*4 +: 4] != 4'd0) blank = 1'b0;
        end
        x.seg_dec = blank ? 7'b0 : decode(nib, 1'b0);
        x.seg_hex = blank ? 7'b0 : decode(nib, 1'b1);
        x.dp = m_act_dp[di];
        x.dig = ~(4'b0001 << di);
      end
      t++;
    end else begin
      t = 0;
    end
    if (ld) begin
      m_pend = d;
      m_pend_dp = p;
    end
    x.fd = e && (t % FRAME == FRAME - 1);
    q.push_back(x);
  endtask

  task automatic run(input int n, input logic [3:0] b);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, digits_in, dp_in, b);
  endtask

  task automatic do_reset();
    @(negedge clk);
    en = 1'b0; load = 1'b0; rst_n = 1'b0;
    #1;
    chk("rst_seg", 32'(seg0), 32'h0);
    chk("rst_dp", 32'(dp0), 32'h0);
    chk("rst_dig", 32'(dig0), 32'hF);
    chk("rst_fd", 32'(fd0), 32'h0);
    t = 0; m_pend = '0; m_act = '0; m_pend_dp = '0; m_act_dp = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: one expected item per clock edge while the model is stepping.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("seg", 32'(seg0), 32'(x.seg_dec));
        chk("seg_hex", 32'(seg1), 32'(x.seg_hex));
        chk("dp", 32'(dp0), 32'(x.dp));
        chk("dp_hex", 32'(dp1), 32'(x.dp));
        chk("dig", 32'(dig0), 32'(x.dig));
        chk("dig_hex", 32'(dig1), 32'(x.dig));
        chk("frame_done", 32'(fd0), 32'(x.fd));
        chk("frame_done_hex", 32'(fd1), 32'(x.fd));
      end
    end
  end

  initial begin
    #400us;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    logic [3:0] b;
    bit e;
    pat[0] = 7'b1111110; pat[1] = 7'b0110000; pat[2] = 7'b1101101; pat[3] = 7'b1111001;
    pat[4] = 7'b0110011; pat[5] = 7'b1011011; pat[6] = 7'b1011111; pat[7] = 7'b1110000;
    pat[8] = 7'b1111111; pat[9] = 7'b1111011; pat[10] = 7'b1110111; pat[11] = 7'b0011111;
    pat[12] = 7'b1001110; pat[13] = 7'b0111101; pat[14] = 7'b1001111; pat[15] = 7'b1000111;

    do_reset();
    step(1'b0, 1'b0, 16'h0, 4'h0, 4'd15);
    // Basic scan with dp on digit 2, full brightness
    step(1'b0, 1'b1, 16'h1234, 4'b0100, 4'd15);
    run(2 * FRAME, 4'd15);
    // Leading-zero blanking
    step(1'b1, 1'b1, 16'h0007, 4'b0000, 4'd15);
    run(2 * FRAME, 4'd15);
    step(1'b1, 1'b1, 16'h0000, 4'b0000, 4'd15);
    run(2 * FRAME, 4'd15);
    // Mid-frame load must not tear
    step(1'b1, 1'b1, 16'h1234, 4'b0000, 4'd15);
    run(FRAME + 30, 4'd15);
    step(1'b1, 1'b1, 16'h5555, 4'b1010, 4'd15);
    run(FRAME + 40, 4'd15);
    // PWM levels
    run(FRAME, 4'd0);
    run(FRAME, 4'd7);
    // Hex code in digit 1
    step(1'b1, 1'b1, 16'h00B0, 4'b0001, 4'd15);
    run(2 * FRAME, 4'd15);
    // Disable: dark, frame_done quiet, loads still taken
    for (int i = 0; i < 20; i++) step(1'b0, (i == 5), 16'h9876, 4'b1000, 4'd15);
    run(FRAME + 10, 4'd15);
    do_reset();
    run(FRAME, 4'd15);

    for (int i = 0; i < 600; i++) begin
      d = '0;
      for (int k = 0; k < ND; k++) d[k*4 +: 4] = ($urandom_range(0, 9) < 4) ? 4'd0 : 4'($urandom_range(0, 15));
      b = (i % 97 < 60) ? 4'd15 : 4'($urandom_range(0, 15));
      e = ($urandom_range(0, 79) != 0);
      step(e, ($urandom_range(0, 19) == 0), d, 4'($urandom_range(0, 15)), b);
    end

    @(posedge clk);
    #2;
    chk("drain", 32'(q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
